// File: rtl/sdram_host_pkg.sv
// rtl/sdram_host_pkg.sv - shared SDRAM host command opcodes and assembler state encoding
package sdram_host_pkg;

   localparam logic [7:0] OPC_WRITE = 8'h01;
   localparam logic [7:0] OPC_READ  = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPC    = 2'd1,
      ST_FIELDS = 2'd2,
      ST_ISSUE  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_cmd_assembler.sv
// rtl/fifo_cmd_assembler.sv - pops host FIFO bytes, frames opcode/address/data into SDRAM commands
module fifo_cmd_assembler
   import sdram_host_pkg::*;
#(
   parameter int ADDR_BYTES = 3,
   parameter int DATA_BYTES = 2,
   parameter int ERR_W      = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    fifo_empty,
   input  logic [7:0]              fifo_rd_data,
   output logic                    fifo_rd_en,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic                    cmd_we,
   output logic [8*ADDR_BYTES-1:0] cmd_addr,
   output logic [8*DATA_BYTES-1:0] cmd_wdata,
   output logic                    busy,
   output logic [ERR_W-1:0]        err_count
);

   localparam int AW      = 8 * ADDR_BYTES;
   localparam int DW      = 8 * DATA_BYTES;
   localparam int MAX_LEN = ADDR_BYTES + DATA_BYTES;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] LEN_WR = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_RD = LEN_W'(ADDR_BYTES);

   state_t             r_state;
   state_t             w_next;
   logic               r_pop_q;
   logic [LEN_W-1:0]   r_popped;
   logic [LEN_W-1:0]   r_captured;
   logic [LEN_W-1:0]   r_len;
   logic [AW-1:0]      r_addr;
   logic [DW-1:0]      r_wdata;
   logic               r_we;
   logic [ERR_W-1:0]   r_err;

   logic               w_opc_wr;
   logic               w_opc_rd;
   logic               w_capture;
   logic               w_last;

   assign w_opc_wr  = (fifo_rd_data == OPC_WRITE);
   assign w_opc_rd  = (fifo_rd_data == OPC_READ);
   assign w_capture = (r_state == ST_FIELDS) && r_pop_q;
   assign w_last    = w_capture && ((r_captured + LEN_W'(1)) == r_len);

   assign cmd_valid = (r_state == ST_ISSUE);
   assign cmd_we    = r_we;
   assign cmd_addr  = r_addr;
   assign cmd_wdata = r_wdata;
   assign busy      = (r_state != ST_IDLE);
   assign err_count = r_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // OPC never pops: the opcode byte must be decoded before the field length is known.
   always_comb begin
      w_next     = r_state;
      fifo_rd_en = 1'b0;
      case (r_state)
         ST_IDLE: begin
            fifo_rd_en = !fifo_empty;
            if (!fifo_empty) begin
               w_next = ST_OPC;
            end
         end
         ST_OPC: begin
            w_next = (w_opc_wr || w_opc_rd) ? ST_FIELDS : ST_IDLE;
         end
         ST_FIELDS: begin
            fifo_rd_en = !fifo_empty && (r_popped < r_len);
            if (w_last) begin
               w_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pop_q    <= 1'b0;
         r_popped   <= '0;
         r_captured <= '0;
         r_len      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_err      <= '0;
      end else begin
         r_pop_q <= fifo_rd_en;
         case (r_state)
            ST_OPC: begin
               r_popped   <= '0;
               r_captured <= '0;
               if (w_opc_wr) begin
                  r_len <= LEN_WR;
                  r_we  <= 1'b1;
               end else if (w_opc_rd) begin
                  r_len   <= LEN_RD;
                  r_we    <= 1'b0;
                  r_wdata <= '0;
               end else if (r_err != {ERR_W{1'b1}}) begin
                  r_err <= r_err + ERR_W'(1);
               end
            end
            ST_FIELDS: begin
               if (fifo_rd_en) begin
                  r_popped <= r_popped + LEN_W'(1);
               end
               // Address bytes fill first, then write data; both shift in MSB first.
               if (w_capture) begin
                  r_captured <= r_captured + LEN_W'(1);
                  if (r_captured < LEN_RD) begin
                     r_addr <= AW'({r_addr, fifo_rd_data});
                  end else begin
                     r_wdata <= DW'({r_wdata, fifo_rd_data});
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_cmd_assembler.sv
// tb/tb_fifo_cmd_assembler.sv - directed-vector bench for fifo_cmd_assembler with a behavioural host FIFO
module tb_fifo_cmd_assembler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fifo_empty;
   logic [7:0]  fifo_rd_data = 8'h00;
   logic        fifo_rd_en;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [23:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        busy;
   logic [7:0]  err_count;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] mem [0:1023];
   int         wr_ptr  = 0;
   int         rd_ptr  = 0;
   int         pop_cnt = 0;
   logic       bad_pop = 1'b0;

   logic        got_we    [0:15];
   logic [23:0] got_addr  [0:15];
   logic [15:0] got_wdata [0:15];
   int          n_cmd = 0;

   fifo_cmd_assembler #(
      .ADDR_BYTES (3),
      .DATA_BYTES (2),
      .ERR_W      (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_we       (cmd_we),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .busy         (busy),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);

   // Host FIFO read side: data appears the cycle after a pop; system reset flushes it.
   always @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd_en) begin
         if (fifo_empty) begin
            bad_pop <= 1'b1;
         end else begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            pop_cnt      <= pop_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && cmd_valid && cmd_ready && n_cmd < 16) begin
         got_we[n_cmd]    <= cmd_we;
         got_addr[n_cmd]  <= cmd_addr;
         got_wdata[n_cmd] <= cmd_wdata;
         n_cmd            <= n_cmd + 1;
      end
   end

   task automatic check_vec(input string tag, input logic [39:0] got, input logic [39:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int k);
      k = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic wait_cmds(input string tag, input int n);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (n_cmd >= n) break;
      end
      check_vec(tag, 40'(n_cmd), 40'(n));
      step(1);
   endtask

   task automatic wait_idle(input string tag);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (fifo_empty && !busy) begin
            done = 1'b1;
            break;
         end
      end
      check_vec(tag, 40'(done), 40'd1);
      step(1);
   endtask

   task automatic chk_cmd(input string tag, input int idx, input logic we,
                          input logic [23:0] addr, input logic [15:0] wdata);
      check_vec({tag, "_we"},    40'(got_we[idx]),    40'(we));
      check_vec({tag, "_addr"},  40'(got_addr[idx]),  40'(addr));
      check_vec({tag, "_wdata"}, 40'(got_wdata[idx]), 40'(wdata));
   endtask

   task automatic chk_reset_outputs(input string tag);
      check_vec({tag, "_rd_en"}, 40'(fifo_rd_en), 40'd0);
      check_vec({tag, "_valid"}, 40'(cmd_valid),  40'd0);
      check_vec({tag, "_we"},    40'(cmd_we),     40'd0);
      check_vec({tag, "_addr"},  40'(cmd_addr),   40'd0);
      check_vec({tag, "_wdata"}, 40'(cmd_wdata),  40'd0);
      check_vec({tag, "_busy"},  40'(busy),       40'd0);
      check_vec({tag, "_err"},   40'(err_count),  40'd0);
   endtask

   initial begin
      int k;
      int base;
      logic [7:0] pkt1 [0:5];
      logic [7:0] b2b  [0:15];
      pkt1 = '{8'h01, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD};
      b2b  = '{8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2,
               8'h02, 8'hC1, 8'hC2, 8'hC3,
               8'h01, 8'hD1, 8'hD2, 8'hD3, 8'hE1, 8'hE2};

      reset_n   = 1'b0;
      cmd_ready = 1'b0;
      step(3);
      @(negedge clk);
      chk_reset_outputs("rst");
      step(1);
      reset_n = 1'b1;
      step(2);

      // WRITE with ready held high; first valid expected in cycle 8
      cmd_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(pkt1[i]);
      @(negedge clk);
      check_vec("wr_c0_rd_en", 40'(fifo_rd_en), 40'd1);
      wait_valid(k);
      check_vec("wr_valid_cycle", 40'(k + 1), 40'd8);
      step(3);
      check_vec("wr_ncmd", 40'(n_cmd), 40'd1);
      chk_cmd("wr", 0, 1'b1, 24'h123456, 16'hABCD);
      check_vec("wr_pops", 40'(pop_cnt), 40'd6);
      check_vec("wr_busy_after", 40'(busy), 40'd0);

      // READ with ready low: command must hold stable
      cmd_ready = 1'b0;
      push(8'h02); push(8'h00); push(8'h00); push(8'h10);
      wait_valid(k);
      check_vec("rd_valid_cycle", 40'(k), 40'd6);
      for (int i = 0; i < 5; i++) begin
         check_vec("rd_hold_valid", 40'(cmd_valid), 40'd1);
         check_vec("rd_hold_we",    40'(cmd_we),    40'd0);
         check_vec("rd_hold_addr",  40'(cmd_addr),  40'h000010);
         check_vec("rd_hold_wdata", 40'(cmd_wdata), 40'd0);
         check_vec("rd_hold_rd_en", 40'(fifo_rd_en), 40'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      cmd_ready = 1'b1;
      @(negedge clk);
      check_vec("rd_valid_at_accept", 40'(cmd_valid), 40'd1);
      @(negedge clk);
      check_vec("rd_valid_after", 40'(cmd_valid), 40'd0);
      step(1);
      check_vec("rd_ncmd", 40'(n_cmd), 40'd2);
      chk_cmd("rd", 1, 1'b0, 24'h000010, 16'h0000);

      // Bad opcode dropped, following READ still framed
      push(8'h7F); push(8'h02); push(8'hAA); push(8'hBB); push(8'hCC);
      wait_cmds("bad_ncmd", 3);
      check_vec("bad_err1", 40'(err_count), 40'd1);
      chk_cmd("bad_rd", 2, 1'b0, 24'hAABBCC, 16'h0000);

      // Saturation boundary of the error counter
      for (int i = 0; i < 253; i++) push(8'h7F);
      wait_idle("sat_idle_a");
      check_vec("sat_err_fe", 40'(err_count), 40'hFE);
      push(8'h33);
      wait_idle("sat_idle_b");
      check_vec("sat_err_ff", 40'(err_count), 40'hFF);
      push(8'h00); push(8'hFF);
      wait_idle("sat_idle_c");
      check_vec("sat_err_hold", 40'(err_count), 40'hFF);
      check_vec("sat_ncmd", 40'(n_cmd), 40'd3);

      // WRITE with FIFO running dry after three bytes
      push(8'h01); push(8'h11); push(8'h22);
      step(5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_vec("gap_rd_en",  40'(fifo_rd_en), 40'd0);
         check_vec("gap_valid",  40'(cmd_valid),  40'd0);
         check_vec("gap_busy",   40'(busy),       40'd1);
      end
      @(posedge clk);
      #1;
      push(8'h33); push(8'h44); push(8'h55);
      wait_cmds("gap_ncmd", 4);
      chk_cmd("gap_wr", 3, 1'b1, 24'h112233, 16'h4455);

      // Reset asserted while stalled in FIELDS
      step(3);
      push(8'h01); push(8'hDE); push(8'hAD);
      step(6);
      check_vec("mid_busy_pre", 40'(busy), 40'd1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("mid_rst");
      push(8'h99);
      step(2);
      reset_n = 1'b1;
      step(1);
      push(8'h02); push(8'h01); push(8'h02); push(8'h03);
      wait_cmds("mid_ncmd", 5);
      chk_cmd("mid_rd", 4, 1'b0, 24'h010203, 16'h0000);

      // Back-to-back WRITE, READ, WRITE with FIFO never empty
      step(3);
      base = pop_cnt;
      for (int i = 0; i < 16; i++) push(b2b[i]);
      wait_cmds("b2b_ncmd", 8);
      step(3);
      chk_cmd("b2b_0", 5, 1'b1, 24'hA1A2A3, 16'hB1B2);
      chk_cmd("b2b_1", 6, 1'b0, 24'hC1C2C3, 16'h0000);
      chk_cmd("b2b_2", 7, 1'b1, 24'hD1D2D3, 16'hE1E2);
      check_vec("b2b_pops", 40'(pop_cnt - base), 40'd16);
      check_vec("b2b_fifo_empty", 40'(fifo_empty), 40'd1);

      check_vec("no_pop_when_empty", 40'(bad_pop), 40'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
